// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 scanning multiplexer.
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // $clog2 that never returns 0, so a single-entry index still has one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// Channel sequencer: dwell counter, channel counter and wrap pulse.
// In manual mode it loads the external index; in scan mode it self-advances.
module mux_scan_ctr
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4,
  localparam int unsigned SW      = clog2_min1(CHANNELS),
  localparam int unsigned DW      = clog2_min1(DWELL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          en_scan,
  input  logic [SW-1:0] load_val,
  output logic [SW-1:0] chan,
  output logic [SW-1:0] chan_next,
  output logic          load_ok,
  output logic          wrap
);

  logic [DW-1:0] dwell_q, dwell_d;
  logic [SW-1:0] chan_q, chan_d;
  logic          wrap_q, wrap_d;

  always_comb begin
    dwell_d = dwell_q;
    chan_d  = chan_q;
    wrap_d  = 1'b0;
    load_ok = (32'(load_val) < CHANNELS);
    if (!hold) begin
      if (en_scan) begin
        if (dwell_q == DW'(DWELL - 1)) begin
          dwell_d = '0;
          if (chan_q == SW'(CHANNELS - 1)) begin
            chan_d = '0;
            wrap_d = 1'b1;
          end else begin
            chan_d = chan_q + SW'(1);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end else begin
        // Manual mode discards any partial dwell; out-of-range index keeps chan.
        dwell_d = '0;
        if (load_ok) begin
          chan_d = load_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      chan_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      chan_q  <= chan_d;
      wrap_q  <= wrap_d;
    end
  end

  assign chan      = chan_q;
  assign chan_next = chan_d;
  assign wrap      = wrap_q;

endmodule

// File: rtl/mux_n1_scan.sv
// Registered N:1 multiplexer with manual select or self-sequencing scan.
// out is loaded from the same channel chan moves to, keeping the pair consistent.
module mux_n1_scan
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DWELL    = 4,
  localparam int unsigned SW      = clog2_min1(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SW-1:0]             sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out,
  output logic [SW-1:0]             chan,
  output logic                      valid,
  output logic                      wrap
);

  logic             en_scan;
  logic [SW-1:0]    chan_next;
  logic             load_ok;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;

  assign en_scan = (mode == MODE_SCAN);

  mux_scan_ctr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .en_scan   (en_scan),
    .load_val  (sel),
    .chan      (chan),
    .chan_next (chan_next),
    .load_ok   (load_ok),
    .wrap      (wrap)
  );

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < int'(CHANNELS); k++) begin
      if (chan_next == SW'(k)) begin
        sel_data = in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (!hold) begin
      valid_d = 1'b1;
      if (!en_scan && !load_ok) begin
        out_d = '0;
      end else begin
        out_d = sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_n1_scan.sv
// Directed bench: a 4-channel/dwell-4 instance and a 3-channel/dwell-1 instance.
module tb_mux_n1_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, CHANNELS=4, DWELL=4
  logic        rst_a, mode_a, hold_a;
  logic [1:0]  sel_a, chan_a;
  logic [7:0]  da [4];
  logic [31:0] in_a;
  logic [7:0]  out_a;
  logic        valid_a, wrap_a;
  assign in_a = {da[3], da[2], da[1], da[0]};

  // Instance B: WIDTH=8, CHANNELS=3, DWELL=1
  logic        rst_b, mode_b, hold_b;
  logic [1:0]  sel_b, chan_b;
  logic [7:0]  db [3];
  logic [23:0] in_b;
  logic [7:0]  out_b;
  logic        valid_b, wrap_b;
  assign in_b = {db[2], db[1], db[0]};

  mux_n1_scan #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) u_dut_a (
    .clk   (clk),
    .rst   (rst_a),
    .in    (in_a),
    .sel   (sel_a),
    .mode  (mode_a),
    .hold  (hold_a),
    .out   (out_a),
    .chan  (chan_a),
    .valid (valid_a),
    .wrap  (wrap_a)
  );

  mux_n1_scan #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) u_dut_b (
    .clk   (clk),
    .rst   (rst_b),
    .in    (in_b),
    .sel   (sel_b),
    .mode  (mode_b),
    .hold  (hold_b),
    .out   (out_b),
    .chan  (chan_b),
    .valid (valid_b),
    .wrap  (wrap_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [1:0] ec, input logic [7:0] eo,
                         input logic ew);
    check({tag, ".chan"}, 32'(chan_a), 32'(ec));
    check({tag, ".out"},  32'(out_a),  32'(eo));
    check({tag, ".wrap"}, 32'(wrap_a), 32'(ew));
  endtask

  initial begin
    da[0] = 8'h11; da[1] = 8'h22; da[2] = 8'h33; da[3] = 8'h44;
    db[0] = 8'hA0; db[1] = 8'hB1; db[2] = 8'hC2;
    rst_a = 1'b1; mode_a = 1'b0; hold_a = 1'b0; sel_a = 2'd0;
    rst_b = 1'b1; mode_b = 1'b0; hold_b = 1'b0; sel_b = 2'd0;

    // Reset state
    step();
    check_a("reset_a", 2'd0, 8'h00, 1'b0);
    check("reset_a.valid", 32'(valid_a), 32'd0);
    check("reset_b.out", 32'(out_b), 32'd0);
    check("reset_b.valid", 32'(valid_b), 32'd0);

    // Manual select of channel 2
    rst_a = 1'b0; sel_a = 2'd2;
    step();
    check_a("manual_sel2", 2'd2, 8'h33, 1'b0);
    check("manual_sel2.valid", 32'(valid_a), 32'd1);

    // Scan from reset: 4 cycles per channel, wrap every 16
    rst_a = 1'b1;
    step();
    rst_a = 1'b0; mode_a = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      step();
      check_a($sformatf("scan_k%0d", k), 2'((k / 4) % 4), da[(k / 4) % 4], (k % 16) == 0);
    end

    // Hold mid-dwell on channel 1; data change during hold must not show
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    repeat (5) step();
    check_a("pre_hold", 2'd1, 8'h22, 1'b0);
    hold_a = 1'b1; da[1] = 8'h2B;
    for (int k = 0; k < 3; k++) begin
      step();
      check_a($sformatf("hold_%0d", k), 2'd1, 8'h22, 1'b0);
    end
    hold_a = 1'b0;
    step();
    check_a("post_hold_0", 2'd1, 8'h2B, 1'b0);
    step();
    check_a("post_hold_1", 2'd1, 8'h2B, 1'b0);
    step();
    check_a("post_hold_adv", 2'd2, 8'h33, 1'b0);
    da[1] = 8'h22;

    // Reset mid-scan at channel 3, together with hold (reset wins)
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    repeat (12) step();
    check("pre_rst.chan", 32'(chan_a), 32'd3);
    rst_a = 1'b1; hold_a = 1'b1;
    step();
    check_a("mid_rst", 2'd0, 8'h00, 1'b0);
    check("mid_rst.valid", 32'(valid_a), 32'd0);
    rst_a = 1'b0; hold_a = 1'b0;
    step();
    check_a("rst_resume_1", 2'd0, 8'h11, 1'b0);
    check("rst_resume.valid", 32'(valid_a), 32'd1);
    da[0] = 8'h5A;
    step();
    check_a("track_data", 2'd0, 8'h5A, 1'b0);
    step();
    check_a("rst_resume_3", 2'd0, 8'h5A, 1'b0);
    step();
    check_a("rst_resume_4", 2'd1, 8'h22, 1'b0);
    da[0] = 8'h11;

    // Scan -> manual (sel=3) -> scan
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    repeat (5) step();
    check("pre_switch.chan", 32'(chan_a), 32'd1);
    mode_a = 1'b0; sel_a = 2'd3;
    step();
    check_a("to_manual", 2'd3, 8'h44, 1'b0);
    mode_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_a($sformatf("rescan_%0d", k), 2'd3, 8'h44, 1'b0);
    end
    step();
    check_a("rescan_wrap", 2'd0, 8'h11, 1'b1);
    step();
    check_a("rescan_after", 2'd0, 8'h11, 1'b0);

    // Instance B: dwell of 1, three channels
    rst_b = 1'b0; mode_b = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("b_scan_k%0d.chan", k), 32'(chan_b), 32'(k % 3));
      check($sformatf("b_scan_k%0d.out", k), 32'(out_b), 32'(db[k % 3]));
      check($sformatf("b_scan_k%0d.wrap", k), 32'(wrap_b), 32'((k % 3) == 0));
    end
    mode_b = 1'b0; sel_b = 2'd1;
    step();
    check("b_manual1.chan", 32'(chan_b), 32'd1);
    check("b_manual1.out", 32'(out_b), 32'hB1);
    sel_b = 2'd3;
    step();
    check("b_oob.chan", 32'(chan_b), 32'd1);
    check("b_oob.out", 32'(out_b), 32'd0);
    check("b_oob.valid", 32'(valid_b), 32'd1);
    sel_b = 2'd2;
    step();
    check("b_manual2.chan", 32'(chan_b), 32'd2);
    check("b_manual2.out", 32'(out_b), 32'hC2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
